// File: rtl/capsense_scan_ctrl.sv
// Time-multiplexed capacitive pad scanner: discharge, release one pad, count charge time,
// then track a per-pad baseline and debounce the touch decision into pressed_o.
module capsense_scan_ctrl #(
    parameter int N         = 4,
    parameter int CNT_W     = 10,
    parameter int MAX_CNT   = 1023,
    parameter int DISCH_CYC = 16,
    parameter int THRESH    = 8,
    parameter int DEB       = 3,
    localparam int CH_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [N-1:0]     pad_i,
    output logic [N-1:0]     pad_oe_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cnt_valid_o,
    output logic [CH_W-1:0]  ch_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [N-1:0]     pressed_o
);

    localparam int DT_W  = (DISCH_CYC > 1) ? $clog2(DISCH_CYC) : 1;
    localparam int DEB_W = $clog2(DEB + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DISCH  = 3'd1;
    localparam logic [2:0] S_CHARGE = 3'd2;
    localparam logic [2:0] S_STORE  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]                r_state;
    logic [CH_W-1:0]           r_ch;
    logic [DT_W-1:0]           r_dtmr;
    logic [CNT_W-1:0]          r_count;
    logic [CH_W-1:0]           r_ch_o;
    logic [CNT_W-1:0]          r_cnt_o;
    logic [N-1:0][CNT_W-1:0]   r_base;
    logic [N-1:0]              r_bvalid;
    logic [N-1:0][DEB_W-1:0]   r_deb;
    logic [N-1:0]              r_pressed;
    logic [N-1:0]              r_sync1;
    logic [N-1:0]              r_sync2;

    logic [CNT_W-1:0]          w_bl;
    logic [CNT_W:0]            w_lim;
    logic                      w_touch;
    logic [DEB_W-1:0]          w_deb_inc;

    // Pads are asynchronous; the synchroniser is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        r_sync1 <= pad_i;
        r_sync2 <= r_sync1;
    end

    // Touch compare done one bit wider so baseline + THRESH cannot overflow.
    assign w_bl      = r_base[r_ch];
    assign w_lim     = {1'b0, w_bl} + (CNT_W+1)'(THRESH);
    assign w_touch   = ({1'b0, r_count} > w_lim);
    assign w_deb_inc = r_deb[r_ch] + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_dtmr    <= '0;
            r_count   <= '0;
            r_ch_o    <= '0;
            r_cnt_o   <= '0;
            r_base    <= '0;
            r_bvalid  <= '0;
            r_deb     <= '0;
            r_pressed <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_DISCH;
                        r_ch    <= '0;
                        r_dtmr  <= '0;
                    end
                end
                S_DISCH: begin
                    if (r_dtmr == DT_W'(DISCH_CYC - 1)) begin
                        r_state <= S_CHARGE;
                        r_count <= '0;
                    end else begin
                        r_dtmr <= r_dtmr + 1'b1;
                    end
                end
                S_CHARGE: begin
                    // Count saturates at MAX_CNT; a pad that never rises still moves the scan on.
                    if (r_sync2[r_ch] || (r_count == CNT_W'(MAX_CNT))) begin
                        r_state <= S_STORE;
                        r_ch_o  <= r_ch;
                        r_cnt_o <= r_count;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_STORE: begin
                    if (!r_bvalid[r_ch]) begin
                        r_base[r_ch]   <= r_count;
                        r_bvalid[r_ch] <= 1'b1;
                    end else begin
                        if (!w_touch) begin
                            if (r_count < w_bl)      r_base[r_ch] <= r_count;
                            else if (r_count > w_bl) r_base[r_ch] <= w_bl + 1'b1;
                        end
                        if (w_touch != r_pressed[r_ch]) begin
                            if (w_deb_inc == DEB_W'(DEB)) begin
                                r_pressed[r_ch] <= ~r_pressed[r_ch];
                                r_deb[r_ch]     <= '0;
                            end else begin
                                r_deb[r_ch] <= w_deb_inc;
                            end
                        end else begin
                            r_deb[r_ch] <= '0;
                        end
                    end
                    if (r_ch == CH_W'(N - 1)) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_dtmr  <= '0;
                        r_state <= S_DISCH;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // OE is decoded from state so an async reset re-discharges every pad immediately.
    assign pad_oe_o    = (r_state == S_CHARGE) ? ~(N'(1) << r_ch) : '1;
    assign busy_o      = (r_state == S_DISCH) || (r_state == S_CHARGE) || (r_state == S_STORE);
    assign done_o      = (r_state == S_FINISH);
    assign cnt_valid_o = (r_state == S_STORE);
    assign ch_o        = r_ch_o;
    assign cnt_o       = r_cnt_o;
    assign pressed_o   = r_pressed;

endmodule

// File: tb/tb_capsense_scan_ctrl.sv
// Directed bench for capsense_scan_ctrl: table of whole-scan vectors plus hand-written
// sequences for idle, discharge length, ignored start and mid-scan reset.
module tb_capsense_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] pad = 4'h0;
    logic [3:0] pad_oe;
    logic       busy, done, cvalid;
    logic [1:0] ch;
    logic [9:0] cnt;
    logic [3:0] pressed;

    int n_vec = 0;
    int n_err = 0;
    int kcur[4];
    int pcnt[4];
    int got_cnt[4];
    int got_ch[4];
    int nvalid, ndone;

    typedef struct packed {
        logic [3:0][11:0] k;
        logic [3:0][9:0]  c;
        logic [3:0]       pr;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    capsense_scan_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .pad_i       (pad),
        .pad_oe_o    (pad_oe),
        .busy_o      (busy),
        .done_o      (done),
        .cnt_valid_o (cvalid),
        .ch_o        (ch),
        .cnt_o       (cnt),
        .pressed_o   (pressed)
    );

    // Pad model: rises K clock edges after its OE drops, falls while discharged.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pad_oe[i]) begin
                pcnt[i] <= 0;
                pad[i]  <= 1'b0;
            end else begin
                pcnt[i] <= pcnt[i] + 1;
                pad[i]  <= ((pcnt[i] + 1) >= kcur[i]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mkv(input int k0, k1, k2, k3, c0, c1, c2, c3, input logic [3:0] pr);
        vec_t v;
        v.k[0] = 12'(k0); v.k[1] = 12'(k1); v.k[2] = 12'(k2); v.k[3] = 12'(k3);
        v.c[0] = 10'(c0); v.c[1] = 10'(c1); v.c[2] = 10'(c2); v.c[3] = 10'(c3);
        v.pr   = pr;
        return v;
    endfunction

    task automatic run_scan();
        int cyc;
        nvalid = 0;
        ndone  = 0;
        for (int i = 0; i < 4; i++) begin
            got_cnt[i] = -1;
            got_ch[i]  = -1;
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (ndone == 0 && cyc < 5000) begin
            if (cvalid) begin
                if (nvalid < 4) begin
                    got_ch[nvalid]  = int'(ch);
                    got_cnt[nvalid] = int'(cnt);
                end
                nvalid++;
            end
            if (done) ndone++;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int bad, dcyc, cyc;
        for (int i = 0; i < 4; i++) kcur[i] = 20;

        vecs[0]  = mkv(20,   20, 20, 20, 22,   22, 22, 22, 4'b0000);
        vecs[1]  = mkv(20,   20, 40, 20, 22,   22, 42, 22, 4'b0000);
        vecs[2]  = mkv(20,   20, 40, 20, 22,   22, 42, 22, 4'b0000);
        vecs[3]  = mkv(20,   20, 40, 20, 22,   22, 42, 22, 4'b0100);
        vecs[4]  = mkv(20,   20, 20, 20, 22,   22, 22, 22, 4'b0100);
        vecs[5]  = mkv(20,   20, 20, 20, 22,   22, 22, 22, 4'b0100);
        vecs[6]  = mkv(20,   20, 20, 20, 22,   22, 22, 22, 4'b0000);
        vecs[7]  = mkv(20,   40, 20, 20, 22,   42, 22, 22, 4'b0000);
        vecs[8]  = mkv(20,   40, 20, 20, 22,   42, 22, 22, 4'b0000);
        vecs[9]  = mkv(20,   20, 20, 20, 22,   22, 22, 22, 4'b0000);
        vecs[10] = mkv(20,   40, 20, 20, 22,   42, 22, 22, 4'b0000);
        vecs[11] = mkv(20,   40, 20, 20, 22,   42, 22, 22, 4'b0000);
        vecs[12] = mkv(20,   20, 20, 20, 22,   22, 22, 22, 4'b0000);
        vecs[13] = mkv(2000, 20, 20, 20, 1023, 22, 22, 22, 4'b0000);
        vecs[14] = mkv(2000, 20, 20, 20, 1023, 22, 22, 22, 4'b0000);
        vecs[15] = mkv(2000, 20, 20, 20, 1023, 22, 22, 22, 4'b0001);
        vecs[16] = mkv(2000, 20, 20, 15, 1023, 22, 22, 17, 4'b0001);
        vecs[17] = mkv(2000, 20, 20, 20, 1023, 22, 22, 22, 4'b0001);
        vecs[18] = mkv(2000, 20, 20, 28, 1023, 22, 22, 30, 4'b0001);
        vecs[19] = mkv(2000, 20, 20, 28, 1023, 22, 22, 30, 4'b0001);
        vecs[20] = mkv(2000, 20, 20, 28, 1023, 22, 22, 30, 4'b1001);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst pad_oe", pad_oe, 4'hF);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst cnt_valid", cvalid, 0);
        chk("rst ch", ch, 0);
        chk("rst cnt", cnt, 0);
        chk("rst pressed", pressed, 0);
        rst_n = 1'b1;

        // Idle without start
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (pad_oe !== 4'hF || busy || done || cvalid) bad++;
        end
        chk("idle quiet", bad, 0);

        // Table of full scans
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 4; i++) kcur[i] = int'(vecs[v].k[i]);
            run_scan();
            chk($sformatf("v%0d done", v), ndone, 1);
            chk($sformatf("v%0d nvalid", v), nvalid, 4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("v%0d ch[%0d]", v, i), got_ch[i], i);
                chk($sformatf("v%0d cnt[%0d]", v, i), got_cnt[i], int'(vecs[v].c[i]));
            end
            chk($sformatf("v%0d pressed", v), pressed, vecs[v].pr);
        end

        // Discharge length, and start ignored during CHARGE
        for (int i = 0; i < 4; i++) kcur[i] = 20;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        dcyc = 0;
        while (pad_oe === 4'hF && busy && dcyc < 100) begin
            @(negedge clk);
            dcyc++;
        end
        chk("discharge cycles", dcyc, 16);
        chk("charge oe ch0", pad_oe, 4'hE);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0; nvalid = 0;
        for (int c = 0; c < 400; c++) begin
            if (done) ndone++;
            if (cvalid) nvalid++;
            @(negedge clk);
        end
        chk("ignored start dones", ndone, 1);
        chk("ignored start valids", nvalid, 4);

        // Reset mid-CHARGE aborts and clears baselines
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (pad_oe === 4'hF && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk("pre-abort oe", pad_oe, 4'hE);
        rst_n = 1'b0;
        #1;
        chk("abort oe", pad_oe, 4'hF);
        chk("abort busy", busy, 0);
        chk("abort pressed", pressed, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        kcur[2] = 40;
        run_scan();
        chk("recal cnt2", got_cnt[2], 42);
        chk("recal pressed", pressed, 0);
        for (int s = 0; s < 3; s++) begin
            run_scan();
            chk($sformatf("recal s%0d pressed", s), pressed, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
